// File: rtl/dump_pkg.sv
// ---------------------------------------------------------------------------
// dump_pkg
// Shared definitions for the ROM dump serializer: the controller state
// encoding and the number of bytes carried by one ROM word.
// ---------------------------------------------------------------------------
package dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } dump_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/rom_dump_serializer.sv
// ---------------------------------------------------------------------------
// rom_dump_serializer
// Walks ROM words 0..NUM_WORDS-1, and sends each word to the UART
// transmitter as four bytes, least significant byte first. Every byte waits
// for the transmitter's completion pulse before the next one is issued, so
// the dump is independent of the baud rate.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   start     begins a dump from word 0 (only looked at while idle)
//   busy      high while a dump is in progress, including the done cycle
//   done      one-cycle pulse after the final byte has been transmitted
//   mem_addr  ROM word address
//   mem_rd    ROM read data, valid one cycle after mem_addr changes
//   tx_byte   byte presented to the transmitter, held for the whole byte
//   tx_send   one-cycle request to the transmitter
//   tx_done   transmitter completion pulse (only honoured while waiting)
// ---------------------------------------------------------------------------
module rom_dump_serializer
    import dump_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int NUM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd,
    output logic [7:0]        tx_byte,
    output logic              tx_send,
    input  logic              tx_done
);

    // The word counter is one bit wider than the address so that a dump of
    // the full 2^ADDR_W words compares against its last index without wrap.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(NUM_WORDS - 1);
    localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    dump_state_t     r_state;
    logic [ADDR_W:0] r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [31:0]     r_word;
    logic [7:0]      r_tx_byte;
    logic            r_busy;
    logic            r_done;
    logic            r_tx_send;

    logic [1:0]      w_next_byte;
    logic [7:0]      w_next_lane;

    assign w_next_byte = r_byte_idx + 2'd1;

    // Byte-lane select for the byte that follows the current one; the lane
    // is loaded into r_tx_byte on the same edge that raises tx_send.
    always_comb begin
        w_next_lane = r_word[7:0];
        case (w_next_byte)
            2'd0:    w_next_lane = r_word[7:0];
            2'd1:    w_next_lane = r_word[15:8];
            2'd2:    w_next_lane = r_word[23:16];
            default: w_next_lane = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_tx_byte  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_send  <= 1'b0;
        end else begin
            r_tx_send <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                // Address has been stable for a cycle; ROM output is valid
                // in the next one.
                ST_FETCH: begin
                    r_state <= ST_LATCH;
                end
                // byte_idx is always 0 here, so lane 0 comes straight from
                // the ROM data.
                ST_LATCH: begin
                    r_word    <= mem_rd;
                    r_tx_byte <= mem_rd[7:0];
                    r_tx_send <= 1'b1;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (r_byte_idx != LAST_BYTE) begin
                            r_byte_idx <= w_next_byte;
                            r_tx_byte  <= w_next_lane;
                            r_tx_send  <= 1'b1;
                            r_state    <= ST_SEND;
                        end else if (r_word_idx < LAST_WORD) begin
                            r_word_idx <= r_word_idx + 1'b1;
                            r_byte_idx <= '0;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_send  = r_tx_send;
    assign tx_byte  = r_tx_byte;
    assign mem_addr = r_word_idx[ADDR_W-1:0];

endmodule
